// File: rtl/costas_nco_if.sv
// Sample-side bus of the Costas-loop NCO: loop-filter correction and phase load in,
// accumulator phase and quadrature carrier samples out.
interface costas_nco_if #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 14
);
  logic                      en;
  logic [PHASE_W-1:0]        frequency_df;
  logic                      load;
  logic [PHASE_W-1:0]        phase_init;
  logic [PHASE_W-1:0]        phase_out;
  logic signed [OUT_W-1:0]   cos_out;
  logic signed [OUT_W-1:0]   sin_out;
  logic                      out_valid;

  modport master (
    output en, frequency_df, load, phase_init,
    input  phase_out, cos_out, sin_out, out_valid
  );

  modport slave (
    input  en, frequency_df, load, phase_init,
    output phase_out, cos_out, sin_out, out_valid
  );
endinterface

// File: rtl/costas_nco.sv
// NCO for Costas carrier recovery: 32-bit phase accumulator steered by the loop filter,
// quarter-wave sine ROM with quadrant folding, four register stages from en to cos/sin.
module costas_nco #(
  parameter int                 PHASE_W  = 32,
  parameter int                 ADDR_W   = 10,
  parameter int                 OUT_W    = 14,
  parameter logic [PHASE_W-1:0] F_CENTER = '0
) (
  input  logic        clk,
  input  logic        rst,
  costas_nco_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  // Half-step sample offset keeps LUT[a] and LUT[~a] exactly complementary, so the
  // quadrant fold needs no special case at 0 or pi/2.
  function automatic logic [OUT_W-2:0] lut_entry(input int k);
    real amp;
    real ang;
    int  val;
    amp = real'((1 << (OUT_W - 1)) - 1);
    ang = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(DEPTH);
    val = $rtoi(amp * $sin(ang) + 0.5);
    return val[OUT_W-2:0];
  endfunction

  logic [OUT_W-2:0] lut [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_lut
    assign lut[k] = lut_entry(k);
  end

  logic [PHASE_W-1:0]      acc;
  logic                    v1;
  logic [1:0]              q2;
  logic [ADDR_W-1:0]       a2;
  logic [ADDR_W-1:0]       na2;
  logic                    v2;
  logic [1:0]              q3;
  logic [OUT_W-2:0]        rom_a;
  logic [OUT_W-2:0]        rom_na;
  logic                    v3;
  logic signed [OUT_W-1:0] pos_a;
  logic signed [OUT_W-1:0] pos_na;
  logic signed [OUT_W-1:0] sin_next;
  logic signed [OUT_W-1:0] cos_next;
  logic signed [OUT_W-1:0] sin_r;
  logic signed [OUT_W-1:0] cos_r;
  logic                    valid_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= 1'b0;
      if (bus.load) begin
        acc <= bus.phase_init;
      end else if (bus.en) begin
        acc <= acc + F_CENTER + bus.frequency_df;
        v1  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q2  <= '0;
      a2  <= '0;
      na2 <= '0;
      v2  <= 1'b0;
      q3     <= '0;
      rom_a  <= '0;
      rom_na <= '0;
      v3     <= 1'b0;
    end else begin
      q2  <= acc[PHASE_W-1 -: 2];
      a2  <= acc[PHASE_W-3 -: ADDR_W];
      na2 <= ~acc[PHASE_W-3 -: ADDR_W];
      v2  <= v1;
      q3     <= q2;
      rom_a  <= lut[a2];
      rom_na <= lut[na2];
      v3     <= v2;
    end
  end

  assign pos_a  = signed'({1'b0, rom_a});
  assign pos_na = signed'({1'b0, rom_na});

  always_comb begin
    sin_next = pos_a;
    cos_next = pos_na;
    case (q3)
      2'd0: begin
        sin_next = pos_a;
        cos_next = pos_na;
      end
      2'd1: begin
        sin_next = pos_na;
        cos_next = -pos_a;
      end
      2'd2: begin
        sin_next = -pos_a;
        cos_next = -pos_na;
      end
      default: begin
        sin_next = -pos_na;
        cos_next = pos_a;
      end
    endcase
  end

  // Outputs only move on a token so they hold across en gaps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sin_r   <= '0;
      cos_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= v3;
      if (v3) begin
        sin_r <= sin_next;
        cos_r <= cos_next;
      end
    end
  end

  assign bus.phase_out = acc;
  assign bus.sin_out   = sin_r;
  assign bus.cos_out   = cos_r;
  assign bus.out_valid = valid_r;
endmodule

// File: tb/tb_costas_nco.sv
// Bench for costas_nco: vector table plus hand sequences, with a scoreboard of
// expected cos/sin pairs released when out_valid fires.
module tb_costas_nco;
  localparam logic [31:0] CENTER = 32'h4000_0000;
  localparam real         PI     = 3.14159265358979323846;

  typedef struct {
    logic signed [13:0] s;
    logic signed [13:0] c;
    int                 due;
  } exp_t;

  typedef struct {
    logic               en;
    logic               load;
    logic [31:0]        df;
    logic [31:0]        pinit;
    logic [31:0]        ph;
    logic               has;
    logic signed [13:0] s;
    logic signed [13:0] c;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   valid_count = 0;
  logic armed = 1'b0;
  logic [31:0] model_acc = '0;
  logic signed [13:0] last_s = '0;
  logic signed [13:0] last_c = '0;
  exp_t sb_q[$];
  vec_t tbl[12];

  costas_nco_if #(.PHASE_W(32), .OUT_W(14)) bus ();

  costas_nco #(
    .PHASE_W(32), .ADDR_W(10), .OUT_W(14), .F_CENTER(CENTER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ref_round(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // Independent reference: true sin/cos at the centre of the 12-bit phase cell.
  function automatic exp_t ref_sample(input logic [31:0] ph, input int due);
    real  th;
    int   si;
    int   co;
    exp_t e;
    th = 2.0 * PI * (real'(ph[31:20]) + 0.5) / 4096.0;
    si = ref_round(8191.0 * $sin(th));
    co = ref_round(8191.0 * $cos(th));
    e.s = si[13:0];
    e.c = co[13:0];
    e.due = due;
    return e;
  endfunction

  task automatic apply_stimulus(input logic r, input logic en, input logic ld,
                                input logic [31:0] df, input logic [31:0] pinit,
                                input logic has, input logic signed [13:0] s,
                                input logic signed [13:0] c);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.en = en;
    bus.load = ld;
    bus.frequency_df = df;
    bus.phase_init = pinit;
    @(posedge clk);
    if (!r) begin
      model_acc = '0;
    end else if (ld) begin
      model_acc = pinit;
    end else if (en) begin
      model_acc = model_acc + CENTER + df;
      if (has) begin
        e.s = s;
        e.c = c;
        e.due = cyc + 4;
      end else begin
        e = ref_sample(model_acc, cyc + 4);
      end
      sb_q.push_back(e);
    end
    #1;
    check_output("phase", bus.phase_out, model_acc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 14'sd0, 14'sd0);
  endtask

  always @(posedge clk) begin : monitor
    logic rs;
    exp_t e;
    rs = rst;
    #1;
    if (!rs) begin
      sb_q.delete();
      armed = 1'b1;
      last_s = '0;
      last_c = '0;
      check_output("rst_valid", bus.out_valid, 0);
      check_output("rst_sin", bus.sin_out, 0);
      check_output("rst_cos", bus.cos_out, 0);
    end else if (bus.out_valid) begin
      valid_count++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check_output("latency", cyc, e.due);
        check_output("sin", bus.sin_out, e.s);
        check_output("cos", bus.cos_out, e.c);
        last_s = e.s;
        last_c = e.c;
      end
    end else if (armed) begin
      check_output("hold_sin", bus.sin_out, last_s);
      check_output("hold_cos", bus.cos_out, last_c);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vc0;
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.frequency_df = '0;
    bus.phase_init = '0;

    // CENTER is 2^30; rows wanting a zero centre add -2^30 into df instead.
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h4000_0000, 1'b1,  14'sd8191, -14'sd6};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h8000_0000, 1'b1, -14'sd6,    -14'sd8191};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'hC000_0000, 1'b1, -14'sd8191,  14'sd6};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b1,  14'sd6,     14'sd8191};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h4000_0000, 1'b1,  14'sd8191, -14'sd6};
    tbl[5]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h4000_0000, 1'b0,  14'sd0,     14'sd0};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0,  14'sd0,     14'sd0};
    tbl[7]  = '{1'b1, 1'b0, 32'hBFF0_0000, 32'h0, 32'hFFF0_0000, 1'b1, -14'sd6,     14'sd8191};
    tbl[8]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 14'sd0, 14'sd0};
    tbl[9]  = '{1'b1, 1'b0, 32'hC000_0000, 32'h0, 32'h8000_0000, 1'b1, -14'sd6,    -14'sd8191};
    tbl[10] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0, 32'hD234_5678, 1'b0,  14'sd0,     14'sd0};
    tbl[11] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h1234_5677, 1'b0,  14'sd0,     14'sd0};

    rst = 1'b0;
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 32'd12345, 32'h0, 1'b0, 14'sd0, 14'sd0);
    check_output("rst_no_valid", valid_count, 0);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b1, tbl[i].en, tbl[i].load, tbl[i].df, tbl[i].pinit,
                     tbl[i].has, tbl[i].s, tbl[i].c);
      check_output("tbl_phase", bus.phase_out, tbl[i].ph);
    end
    idle(6);
    check_output("tbl_drain", sb_q.size(), 0);

    vc0 = valid_count;
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 14'sd0, 14'sd0);
    idle(8);
    check_output("single_pulse", valid_count - vc0, 1);
    check_output("gap_hold_sin", bus.sin_out, last_s);

    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_1000 * i, 32'h0, 1'b0, 14'sd0, 14'sd0);
    vc0 = valid_count;
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 14'sd0, 14'sd0);
    idle(5);
    check_output("flush_no_valid", valid_count - vc0, 0);
    check_output("flush_phase", bus.phase_out, 0);
    check_output("flush_sin", bus.sin_out, 0);

    for (int i = 0; i < 40; i++) begin
      logic ld;
      ld = ($urandom_range(0, 7) == 0);
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)), ld, $urandom, $urandom, 1'b0, 14'sd0, 14'sd0);
    end
    idle(6);
    check_output("final_drain", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
